// File: rtl/rmii_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// rmii_rx_deframer_if
// Buffer-side bundle of the RMII receive deframer.
//   o_rx_addr / o_rx_data / o_rx_we : sequential byte writes into the RX RAM
//   o_frame_done / o_frame_len /
//   o_fcs_ok / o_err                : per-frame completion record
//   i_ack                           : one-cycle release of the record
//   o_busy                          : deframer is inside a frame
//   o_drop_cnt                      : frames ignored while a record was pending
// master = deframer side, slave = RX buffer / MAC side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface rmii_rx_deframer_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] o_rx_addr;
  logic [7:0]        o_rx_data;
  logic              o_rx_we;
  logic              o_frame_done;
  logic [ADDR_W-1:0] o_frame_len;
  logic              o_fcs_ok;
  logic              o_err;
  logic              i_ack;
  logic              o_busy;
  logic [7:0]        o_drop_cnt;

  modport master (
    output o_rx_addr, o_rx_data, o_rx_we,
    output o_frame_done, o_frame_len, o_fcs_ok, o_err,
    input  i_ack,
    output o_busy, o_drop_cnt
  );

  modport slave (
    input  o_rx_addr, o_rx_data, o_rx_we,
    input  o_frame_done, o_frame_len, o_fcs_ok, o_err,
    output i_ack,
    input  o_busy, o_drop_cnt
  );
endinterface

// File: rtl/rmii_rx_deframer.sv
// ---------------------------------------------------------------------------
// rmii_rx_deframer
// RMII (100 Mb/s) receive framing stage. Strips preamble/SFD, assembles
// LSB-first bytes from dibits, writes them to the RX buffer from address 0,
// checks the Ethernet FCS and holds a completion record until acknowledged.
//   clk       : 50 MHz RMII reference clock
//   rst       : synchronous, active-high reset
//   i_erxd    : RMII receive dibit, bit 0 first on the wire
//   i_erx_dv  : CRS_DV used as data-valid
//   i_erx_er  : PHY receive error
//   bus       : buffer write port, completion record, ack, busy, drop count
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module rmii_rx_deframer #(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            i_erxd,
  input  logic                  i_erx_dv,
  input  logic                  i_erx_er,
  rmii_rx_deframer_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DISCARD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] MIN_CNT = ADDR_W'(MIN_LEN);
  // Magic residue expressed MSB-first; the reflected register is bit-reversed
  // before the compare (equivalent to register == 0xDEBB20E3).
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  state_t            state, state_nxt;
  logic [5:0]        sh;          // last three dibits of the byte in progress
  logic [1:0]        dcnt;        // dibit position inside the current byte
  logic [ADDR_W-1:0] byte_cnt;
  logic              err_flag;
  logic [31:0]       crc;
  logic              dv_q;

  logic [7:0]        byte_nxt;
  logic [31:0]       crc_rev;
  logic              err_end;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign byte_nxt = {i_erxd, sh};
  // Error state latched into the record when the frame ends this cycle.
  assign err_end  = err_flag | i_erx_er | (dcnt != 2'd0);

  always_comb begin
    crc_rev = '0;
    for (int k = 0; k < 32; k++) crc_rev[k] = crc[31-k];
  end

  assign bus.o_busy = (state == S_PREAMBLE) || (state == S_DATA) ||
                      (state == S_DISCARD);

  // NOTE: non-blocking assignments on every register so all of them sample
  // the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (i_erx_dv && i_erxd == 2'b01) state_nxt = S_PREAMBLE;
      S_PREAMBLE: begin
        if (!i_erx_dv)              state_nxt = S_IDLE;
        else if (i_erxd == 2'b11)   state_nxt = S_DATA;
        else if (i_erxd != 2'b01)   state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (!i_erx_dv)              state_nxt = S_DONE;
        else if (byte_cnt == MAX_CNT) state_nxt = S_DISCARD;
      end
      S_DISCARD:  if (!i_erx_dv) state_nxt = S_DONE;
      S_DONE:     if (bus.i_ack) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh               <= '0;
      dcnt             <= '0;
      byte_cnt         <= '0;
      err_flag         <= 1'b0;
      crc              <= 32'hFFFF_FFFF;
      dv_q             <= 1'b0;
      bus.o_rx_addr    <= '0;
      bus.o_rx_data    <= '0;
      bus.o_rx_we      <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_frame_len  <= '0;
      bus.o_fcs_ok     <= 1'b0;
      bus.o_err        <= 1'b0;
      bus.o_drop_cnt   <= '0;
    end else begin
      bus.o_rx_we <= 1'b0;
      dv_q        <= i_erx_dv;

      unique case (state)
        S_PREAMBLE: begin
          if (i_erx_dv && i_erxd == 2'b11) begin
            dcnt     <= '0;
            byte_cnt <= '0;
            err_flag <= 1'b0;
            crc      <= 32'hFFFF_FFFF;
          end
        end

        S_DATA, S_DISCARD: begin
          if (!i_erx_dv) begin
            // Record built from registers that already include the last
            // write, so it is valid on the cycle after dv falls.
            bus.o_frame_done <= 1'b1;
            bus.o_frame_len  <= byte_cnt;
            bus.o_err        <= err_end;
            bus.o_fcs_ok     <= (crc_rev == CRC_RESIDUE) && !err_end &&
                                (byte_cnt >= MIN_CNT);
          end else if (state == S_DATA) begin
            if (byte_cnt == MAX_CNT) begin
              err_flag <= 1'b1;          // overflow: the rest is discarded
            end else begin
              sh   <= byte_nxt[7:2];
              dcnt <= dcnt + 2'd1;
              if (i_erx_er) err_flag <= 1'b1;
              if (dcnt == 2'd3) begin
                bus.o_rx_we   <= 1'b1;
                bus.o_rx_data <= byte_nxt;
                bus.o_rx_addr <= byte_cnt;
                byte_cnt      <= byte_cnt + ADDR_W'(1);
                crc           <= crc32_byte(crc, byte_nxt);
              end
            end
          end
        end

        S_DONE: begin
          if (bus.i_ack) begin
            bus.o_frame_done <= 1'b0;
            bus.o_fcs_ok     <= 1'b0;
            bus.o_err        <= 1'b0;
          end else if (i_erx_dv && !dv_q && bus.o_drop_cnt != 8'hFF) begin
            bus.o_drop_cnt <= bus.o_drop_cnt + 8'd1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule
